// File: rtl/word_packer.sv
// word_packer: gathers WORD_W-bit words from a show-ahead FIFO into beats of
// PACK_NUM words (word 0 in the LSBs), with a flush that closes a partial beat.
module word_packer #(
    parameter int PACK_NUM = 4,
    parameter int WORD_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty,
    input  logic [WORD_W-1:0]          fifo_data,
    output logic                       fifo_pop,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PACK_NUM*WORD_W-1:0] out_data,
    output logic [PACK_NUM-1:0]        out_keep,
    output logic                       out_last,
    output logic                       flush_done
);

    localparam int                CNT_W    = $clog2(PACK_NUM + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(PACK_NUM);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [WORD_W-1:0]          fill_buf [PACK_NUM];
    logic [CNT_W-1:0]           cnt;
    logic                       flush_pend;

    logic                       close;
    logic                       move;
    logic                       take;
    logic                       flush_clear;
    logic [CNT_W-1:0]           wr_slot;
    logic [PACK_NUM*WORD_W-1:0] beat_data;
    logic [PACK_NUM-1:0]        beat_keep;

    // Beat close / hand-off decision and the pop request back to the FIFO.
    // A full buffer can still take a word in the cycle it hands its beat off,
    // which is what sustains one word per cycle.
    always_comb begin
        close       = (cnt == CNT_FULL) | (flush_pend & (cnt != '0));
        move        = close & (~out_valid | out_ready);
        take        = rst_n & ~fifo_empty & ~flush & ~flush_pend
                      & ((cnt < CNT_FULL) | move);
        fifo_pop    = take;
        wr_slot     = move ? '0 : cnt;
        flush_clear = flush_pend & ((cnt == '0) | move);
    end

    // Assemble the outgoing beat from the filled slots only; stale slots read zero.
    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int i = 0; i < PACK_NUM; i++) begin
            if (CNT_W'(i) < cnt) begin
                beat_data[i*WORD_W +: WORD_W] = fill_buf[i];
                beat_keep[i]                  = 1'b1;
            end
        end
    end

    // Fill buffer write; data-only storage, validity is tracked by cnt.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PACK_NUM; i++) begin
            if (take && (wr_slot == CNT_W'(i))) begin
                fill_buf[i] <= fifo_data;
            end
        end
    end

    // Fill counter: restarts at 0 or 1 when a beat leaves, else counts words taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (move) begin
            cnt <= take ? CNT_ONE : '0;
        end else if (take) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // One-beat output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (move) begin
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_keep  <= beat_keep;
            out_last  <= flush_pend;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Flush bookkeeping: a flush seen while one is pending is absorbed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= flush_clear;
            if (flush_pend) begin
                if (flush_clear) begin
                    flush_pend <= 1'b0;
                end
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: scenario tasks with constant expectations plus a randomized
// run checked cycle by cycle against a queue-based behavioural model.
module tb_word_packer;

    localparam int PACK_NUM = 4;
    localparam int WORD_W   = 32;
    localparam int PW       = PACK_NUM * WORD_W;

    logic              clk;
    logic              rst_n;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_data;
    logic              fifo_pop;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     out_data;
    logic [PACK_NUM-1:0] out_keep;
    logic              out_last;
    logic              flush_done;

    int errors = 0;
    int checks = 0;

    // Upstream FIFO contents (head at index 0)
    logic [WORD_W-1:0] src_q[$];
    // Scenario word storage
    logic [WORD_W-1:0] wbuf[32];

    // Behavioural model: words gathered so far, pending flush, output register
    logic [WORD_W-1:0]   m_fill[$];
    bit                  m_pend;
    bit                  m_ov;
    bit                  m_last;
    bit                  m_fd;
    logic [PW-1:0]       m_data;
    logic [PACK_NUM-1:0] m_keep;

    word_packer #(.PACK_NUM(PACK_NUM), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .flush_done (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_move();
        bit cl;
        cl = (m_fill.size() == PACK_NUM) || (m_pend && m_fill.size() != 0);
        return cl && (!m_ov || (out_ready === 1'b1));
    endfunction

    function automatic bit model_pop();
        return (rst_n === 1'b1) && (fifo_empty === 1'b0) && (flush === 1'b0) && !m_pend
               && ((m_fill.size() < PACK_NUM) || model_move());
    endfunction

    function automatic logic [PW-1:0] expect_beat(input int base, input int n);
        logic [PW-1:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[i*WORD_W +: WORD_W] = wbuf[base + i];
        return d;
    endfunction

    task automatic drive_src();
        fifo_empty = (src_q.size() == 0);
        fifo_data  = (src_q.size() != 0) ? src_q[0] : '0;
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w);
        src_q.push_back(w);
        drive_src();
    endtask

    // Advance one clock: model and source FIFO follow the pre-edge inputs.
    task automatic tick();
        bit p_take, p_move, p_clear, p_flush, p_ready, p_rst, p_pop;
        logic [WORD_W-1:0] p_head, dummy;
        p_take  = model_pop();
        p_move  = model_move();
        p_clear = m_pend && (m_fill.size() == 0 || p_move);
        p_head  = fifo_data;
        p_flush = (flush === 1'b1);
        p_ready = (out_ready === 1'b1);
        p_rst   = (rst_n === 1'b1);
        p_pop   = (fifo_pop === 1'b1);
        @(posedge clk);
        if (!p_rst) begin
            m_fill.delete();
            m_pend = 0; m_ov = 0; m_last = 0; m_fd = 0;
            m_data = '0; m_keep = '0;
        end else begin
            if (p_move) begin
                m_data = '0;
                m_keep = '0;
                for (int i = 0; i < m_fill.size(); i++) begin
                    m_data[i*WORD_W +: WORD_W] = m_fill[i];
                    m_keep[i] = 1'b1;
                end
                m_last = m_pend;
                m_ov   = 1;
                m_fill.delete();
            end else if (m_ov && p_ready) begin
                m_ov = 0;
            end
            if (p_take) m_fill.push_back(p_head);
            m_fd = p_clear;
            if (m_pend) m_pend = !p_clear;
            else        m_pend = p_flush;
        end
        #1;
        if (p_pop && src_q.size() != 0) dummy = src_q.pop_front();
        drive_src();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        src_q.delete();
        drive_src();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        push_word(32'hDEAD_BEEF);
        #1;
        checks++;
        if (fifo_pop !== 1'b0) begin
            errors++; $display("FAIL reset_pop: got %b, want 0", fifo_pop);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || flush_done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got valid=%b last=%b done=%b, want 0 0 0",
                               out_valid, out_last, flush_done);
        end
        checks++;
        if (out_data !== '0 || out_keep !== '0) begin
            errors++; $display("FAIL reset_data: got data=%h keep=%b, want zeros", out_data, out_keep);
        end
        src_q.delete();
        drive_src();
    endtask

    task automatic test_full_beat();
        int pops, beats, first_valid;
        logic [PW-1:0] exp_d;
        do_reset();
        out_ready = 1'b1;
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        exp_d = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
        pops = 0; beats = 0; first_valid = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (fifo_pop === 1'b1) pops++;
            if (out_valid === 1'b1) begin
                if (first_valid < 0) first_valid = c;
                beats++;
                checks++;
                if (out_data !== exp_d || out_keep !== 4'b1111 || out_last !== 1'b0) begin
                    errors++; $display("FAIL full_beat: got data=%h keep=%b last=%b, want %h 1111 0",
                                       out_data, out_keep, out_last, exp_d);
                end
            end
            tick();
        end
        checks++;
        if (pops != 4) begin errors++; $display("FAIL full_beat_pops: got %0d, want 4", pops); end
        checks++;
        if (beats != 1) begin errors++; $display("FAIL full_beat_count: got %0d, want 1", beats); end
        checks++;
        if (first_valid != 5) begin
            errors++; $display("FAIL full_beat_latency: got cycle %0d, want 5", first_valid);
        end
    endtask

    task automatic test_backpressure();
        int pops, nb;
        logic [PW-1:0] exp_d;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wbuf[i] = $urandom;
            push_word(wbuf[i]);
        end
        exp_d = expect_beat(0, 4);
        pops = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (fifo_pop === 1'b1) pops++;
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== exp_d || out_keep !== 4'b1111 || out_last !== 1'b0) begin
                    errors++; $display("FAIL bp_hold: cycle %0d got data=%h keep=%b, want %h 1111",
                                       c, out_data, out_keep, exp_d);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (pops != 8) begin errors++; $display("FAIL bp_pops: got %0d, want 8", pops); end
        checks++;
        if (fifo_pop !== 1'b0) begin errors++; $display("FAIL bp_stall_pop: got %b, want 0", fifo_pop); end
        tick();
        out_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (fifo_pop === 1'b1) pops++;
            if (out_valid === 1'b1) begin
                checks++;
                if (nb >= 3) begin
                    errors++; $display("FAIL bp_extra_beat: got beat %0d, want 3 beats", nb);
                end else if (out_data !== expect_beat(4*nb, 4) || out_keep !== 4'b1111) begin
                    errors++; $display("FAIL bp_beat%0d: got %h, want %h", nb, out_data, expect_beat(4*nb, 4));
                end
                nb++;
            end
            tick();
        end
        checks++;
        if (nb != 3) begin errors++; $display("FAIL bp_beats: got %0d, want 3", nb); end
        checks++;
        if (pops != 12) begin errors++; $display("FAIL bp_total_pops: got %0d, want 12", pops); end
    endtask

    task automatic test_flush_partial();
        int nb, nfd, beat_cyc, fd_cyc, first_pop_after;
        logic [PW-1:0] exp_d;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = $urandom;
            push_word(wbuf[i]);
        end
        exp_d = expect_beat(0, 3);
        nb = 0; nfd = 0; beat_cyc = -1; fd_cyc = -1; first_pop_after = -1;
        for (int c = 0; c < 12; c++) begin
            flush = (c == 3 || c == 4);
            #1;
            if (flush === 1'b1) begin
                checks++;
                if (fifo_pop !== 1'b0) begin
                    errors++; $display("FAIL flush_blocks_pop: cycle %0d got %b, want 0", c, fifo_pop);
                end
            end
            if (c > 4 && fifo_pop === 1'b1 && first_pop_after < 0) first_pop_after = c;
            if (out_valid === 1'b1) begin
                nb++; beat_cyc = c;
                checks++;
                if (out_data !== exp_d || out_keep !== 4'b0111 || out_last !== 1'b1) begin
                    errors++; $display("FAIL flush_beat: got data=%h keep=%b last=%b, want %h 0111 1",
                                       out_data, out_keep, out_last, exp_d);
                end
            end
            if (flush_done === 1'b1) begin nfd++; fd_cyc = c; end
            tick();
        end
        flush = 1'b0;
        checks++;
        if (nb != 1 || beat_cyc != 5) begin
            errors++; $display("FAIL flush_beat_count: got %0d beats at %0d, want 1 at 5", nb, beat_cyc);
        end
        checks++;
        if (nfd != 1 || fd_cyc != 5) begin
            errors++; $display("FAIL flush_done_partial: got %0d pulses at %0d, want 1 at 5", nfd, fd_cyc);
        end
        checks++;
        if (first_pop_after != 5) begin
            errors++; $display("FAIL flush_resume: got first pop %0d, want 5", first_pop_after);
        end
    endtask

    task automatic test_flush_empty();
        int nv, nfd, fd_cyc;
        do_reset();
        out_ready = 1'b1;
        nv = 0; nfd = 0; fd_cyc = -1;
        for (int c = 0; c < 8; c++) begin
            flush = (c == 0);
            #1;
            if (out_valid === 1'b1) nv++;
            if (flush_done === 1'b1) begin nfd++; fd_cyc = c; end
            tick();
        end
        flush = 1'b0;
        checks++;
        if (nv != 0) begin errors++; $display("FAIL flush_empty_beat: got %0d beats, want 0", nv); end
        checks++;
        if (nfd != 1 || fd_cyc != 2) begin
            errors++; $display("FAIL flush_empty_done: got %0d pulses at %0d, want 1 at 2", nfd, fd_cyc);
        end
    endtask

    task automatic test_reset_midfill();
        int nb;
        do_reset();
        out_ready = 1'b1;
        push_word(32'hAAAA_0001);
        push_word(32'hAAAA_0002);
        for (int c = 0; c < 2; c++) begin #1; tick(); end
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = $urandom;
            push_word(wbuf[i]);
        end
        #1;
        checks++;
        if (fifo_pop !== 1'b0) begin errors++; $display("FAIL midfill_reset_pop: got %b, want 0", fifo_pop); end
        tick();
        rst_n = 1'b1;
        nb = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                nb++;
                checks++;
                if (out_data !== expect_beat(0, 4) || out_keep !== 4'b1111) begin
                    errors++; $display("FAIL midfill_beat: got data=%h keep=%b, want %h 1111",
                                       out_data, out_keep, expect_beat(0, 4));
                end
            end
            tick();
        end
        checks++;
        if (nb != 1) begin errors++; $display("FAIL midfill_beats: got %0d, want 1", nb); end
    endtask

    task automatic test_back_to_back();
        int pops, first, last, nb;
        int vc[4];
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = $urandom;
            push_word(wbuf[i]);
        end
        pops = 0; first = -1; last = -1; nb = 0;
        for (int c = 0; c < 26; c++) begin
            #1;
            if (fifo_pop === 1'b1) begin
                pops++;
                if (first < 0) first = c;
                last = c;
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (nb >= 4) begin
                    errors++; $display("FAIL b2b_extra_beat: got beat %0d, want 4 beats", nb);
                end else begin
                    vc[nb] = c;
                    if (out_data !== expect_beat(4*nb, 4) || out_keep !== 4'b1111) begin
                        errors++; $display("FAIL b2b_beat%0d: got %h, want %h", nb, out_data, expect_beat(4*nb, 4));
                    end
                end
                nb++;
            end
            tick();
        end
        checks++;
        if (pops != 16 || first != 0 || last != 15) begin
            errors++; $display("FAIL b2b_pops: got %0d pops in cycles %0d..%0d, want 16 in 0..15", pops, first, last);
        end
        checks++;
        if (nb != 4) begin
            errors++; $display("FAIL b2b_beats: got %0d, want 4", nb);
        end else if (vc[0] != 5 || vc[1] != 9 || vc[2] != 13 || vc[3] != 17) begin
            errors++; $display("FAIL b2b_spacing: got %0d %0d %0d %0d, want 5 9 13 17", vc[0], vc[1], vc[2], vc[3]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if (src_q.size() < 6 && $urandom_range(0, 3) != 0) push_word($urandom);
            #1;
            checks++;
            if (fifo_pop !== model_pop()) begin
                errors++; $display("FAIL rnd_pop: cycle %0d got %b, want %b", c, fifo_pop, model_pop());
            end
            checks++;
            if (fifo_pop === 1'b1 && fifo_empty === 1'b1) begin
                errors++; $display("FAIL rnd_pop_empty: cycle %0d got pop with empty FIFO, want 0", c);
            end
            checks++;
            if (out_valid !== m_ov) begin
                errors++; $display("FAIL rnd_valid: cycle %0d got %b, want %b", c, out_valid, m_ov);
            end
            if (m_ov) begin
                checks++;
                if (out_data !== m_data || out_keep !== m_keep || out_last !== m_last) begin
                    errors++; $display("FAIL rnd_beat: cycle %0d got %h/%b/%b, want %h/%b/%b",
                                       c, out_data, out_keep, out_last, m_data, m_keep, m_last);
                end
            end
            checks++;
            if (flush_done !== m_fd) begin
                errors++; $display("FAIL rnd_flush_done: cycle %0d got %b, want %b", c, flush_done, m_fd);
            end
            tick();
        end
        rst_n = 1'b1;
        flush = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        m_fill.delete();
        m_pend = 0; m_ov = 0; m_last = 0; m_fd = 0;
        m_data = '0; m_keep = '0;
        test_reset();
        test_full_beat();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_reset_midfill();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 The module SHALL have parameter PACK_NUM, default 4, giving the words per output beat (legal values 2 and above).
REQ-002 The module SHALL have parameter WORD_W, default 32, giving the width of one word in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port fifo_empty, input, 1 bit: upstream FIFO holds no word.
REQ-006 Port fifo_data, input, WORD_W bits: upstream FIFO head word, valid whenever fifo_empty=0 (show-ahead).
REQ-007 Port fifo_pop, output, 1 bit: combinational pop request; a word is consumed in the same cycle.
REQ-008 Port flush, input, 1 bit: single-cycle request to close the current partial beat.
REQ-009 Port out_valid, output, 1 bit: output beat present.
REQ-010 Port out_ready, input, 1 bit: downstream accepts the beat.
REQ-011 Port out_data, output, PACK_NUM*WORD_W bits: packed beat, word 0 in the LSBs.
REQ-012 Port out_keep, output, PACK_NUM bits: per-word valid mask.
REQ-013 Port out_last, output, 1 bit: the beat was closed by a flush.
REQ-014 Port flush_done, output, 1 bit: one-cycle pulse when a flush completes.

Function
REQ-015 The module SHALL contain a fill buffer of PACK_NUM words, a fill counter cnt (0..PACK_NUM, width $clog2(PACK_NUM+1)), a one-beat output register and a flush_pend flag.
REQ-016 The module SHALL define close = (cnt==PACK_NUM) | (flush_pend & cnt!=0), and move = close & (~out_valid | out_ready).
REQ-017 The module SHALL drive fifo_pop = rst_n & ~fifo_empty & ~flush & ~flush_pend & (cnt<PACK_NUM | move); fifo_pop SHALL never assert while fifo_empty=1.
REQ-018 When fifo_pop=1, the module SHALL capture fifo_data in the same cycle into buffer slot cnt, or into slot 0 when move=1.
REQ-019 On move, the module SHALL load out_data from the buffer, with unfilled slots set to zero, set out_keep bit i for each i<cnt, set out_last=flush_pend, and set out_valid=1.
REQ-020 On move, cnt SHALL become 1 if a word is taken in the same cycle, and 0 otherwise.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_keep and out_last SHALL stay stable.
REQ-022 When out_valid=1, out_ready=1 and move=0, out_valid SHALL fall to 0 on the next edge.
REQ-023 Simultaneous acceptance of a beat and move SHALL load the next beat with no bubble.
REQ-024 Latency: a word taken in cycle t that fills the buffer SHALL appear on out_data at t+2 if the output register is free.
REQ-025 Sustained throughput SHALL be one word per cycle, giving one beat every PACK_NUM cycles when out_ready=1.
REQ-026 flush=1 SHALL set flush_pend on the next edge.
REQ-027 While flush or flush_pend is high, no word SHALL be taken.
REQ-028 If flush_pend=1 and cnt=0, the module SHALL clear flush_pend and pulse flush_done for one cycle without emitting a beat.
REQ-029 If flush_pend=1 and cnt>0, the module SHALL clear flush_pend and pulse flush_done for one cycle in the cycle after move.
REQ-030 A flush asserted while flush_pend=1 SHALL be absorbed with no second effect.

Reset
REQ-031 While rst_n=0 at an edge, the module SHALL clear cnt, out_valid, out_keep, out_last, out_data, flush_pend and flush_done to 0.
REQ-032 While rst_n=0, fifo_pop SHALL be 0.
REQ-033 Reset asserted mid-fill SHALL discard the partial words, and the next word after reset SHALL land in slot 0.

Verification
REQ-034 Scenario: PACK_NUM=4, WORD_W=32, out_ready=1, push 0x11,0x22,0x33,0x44 -> one beat with out_data=0x00000044_00000033_00000022_00000011, out_keep=4'b1111, out_last=0, exactly 4 pops.
REQ-035 Scenario: 12 words queued, out_ready=0 for 12 cycles -> first beat held stable, exactly 8 pops and then fifo_pop=0; release out_ready -> beats 2 and 3 delivered in order with no loss.
REQ-036 Scenario: 3 words then flush -> beat with out_keep=4'b0111, top word 0, out_last=1, and flush_done pulses once, 1 cycle after move.
REQ-037 Scenario: flush with cnt=0 and out idle -> no beat, and flush_done pulses once, 2 cycles after flush.
REQ-038 Scenario: rst_n low for 1 cycle after 2 words taken, then 4 new words -> a single beat containing only the new words, out_keep=4'b1111.
REQ-039 Scenario: 16 words back-to-back with out_ready=1 -> fifo_pop high 16 consecutive cycles and 4 beats with no gaps between fills.
